// File: rtl/branch_target_pipe_if.sv
// branch_target_pipe_if -- operand/result bundle for branch_target_pipe.
//
// Parameters:
//   ADDR_W  width of PC, offset and target
//   CNT_W   width of the taken-branch counter
//
// Signals (master drives operands/controls, slave drives results):
//   in_valid   operands valid this cycle
//   pc_next    incremented PC from the fetch buffer
//   offset     pre-shifted two's-complement branch offset
//   branch_en  branch condition (branch opcode AND zero flag)
//   stall      hold the whole pipeline
//   flush      kill all in-flight entries
//   out_valid  target/taken valid this cycle
//   target     branch target, 0 when not taken
//   taken      registered branch_en of the retiring entry
//   taken_cnt  saturating count of retired taken branches
//   ovf        signed overflow of retiring sum (only with BTP_OVF_DETECT_EN)
//
// Optional feature macro: BTP_OVF_DETECT_EN
interface branch_target_pipe_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 4
);
  logic              in_valid;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] offset;
  logic              branch_en;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [ADDR_W-1:0] target;
  logic              taken;
  logic [CNT_W-1:0]  taken_cnt;
`ifdef BTP_OVF_DETECT_EN
  logic              ovf;

  modport master (
    output in_valid, pc_next, offset, branch_en, stall, flush,
    input  out_valid, target, taken, taken_cnt, ovf
  );

  modport slave (
    input  in_valid, pc_next, offset, branch_en, stall, flush,
    output out_valid, target, taken, taken_cnt, ovf
  );
`else
  modport master (
    output in_valid, pc_next, offset, branch_en, stall, flush,
    input  out_valid, target, taken, taken_cnt
  );

  modport slave (
    input  in_valid, pc_next, offset, branch_en, stall, flush,
    output out_valid, target, taken, taken_cnt
  );
`endif
endinterface

// File: rtl/branch_target_pipe.sv
// branch_target_pipe -- two-stage branch target adder.
//
// S1 registers the operands (in_valid, pc_next, offset, branch_en); S2 adds
// pc_next + offset modulo 2^ADDR_W and registers target/taken/out_valid.
// Operands accepted at edge N appear on the outputs after edge N+1; one new
// entry may be accepted every unstalled cycle.
//
// Control priority at each rising edge: rst > flush > stall.
//   rst   clears valid bits, outputs and taken_cnt
//   flush clears valid bits and outputs, keeps taken_cnt
//   stall freezes every register, ignores the inputs
//
// Parameters:
//   ADDR_W  width of PC, offset and target (default 6)
//   CNT_W   width of taken_cnt (default 4)
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   branch_target_pipe_if.slave (operands in, results out)
//
// Optional feature macro: BTP_OVF_DETECT_EN
//   When defined, bus.ovf flags signed overflow of a retiring taken entry.
//   When undefined, the ovf port and its logic do not exist.
module branch_target_pipe #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 4
) (
  input logic                  clk,
  input logic                  rst,
  branch_target_pipe_if.slave  bus
);

  // Stage 1 operand registers
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_pc;
  logic [ADDR_W-1:0] s1_off;
  logic              s1_en;

  // Stage 2 combinational results
  logic [ADDR_W-1:0] sum;
  logic              retire_taken;
  logic              cnt_full;

  always_comb begin
    sum          = s1_pc + s1_off;
    retire_taken = s1_valid & s1_en;
    cnt_full     = (bus.taken_cnt == {CNT_W{1'b1}});
  end

`ifdef BTP_OVF_DETECT_EN
  // Overflow: operands share a sign and the sum's sign differs from it.
  logic ovf_cond;

  always_comb begin
    ovf_cond = (s1_pc[ADDR_W-1] == s1_off[ADDR_W-1]) &&
               (sum[ADDR_W-1] != s1_pc[ADDR_W-1]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_pc         <= '0;
      s1_off        <= '0;
      s1_en         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.target    <= '0;
      bus.taken     <= 1'b0;
      bus.taken_cnt <= '0;
`ifdef BTP_OVF_DETECT_EN
      bus.ovf       <= 1'b0;
`endif
    end else if (bus.flush) begin
      // Kill both stages; operands are don't-care once the valid bit drops.
      s1_valid      <= 1'b0;
      s1_en         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.target    <= '0;
      bus.taken     <= 1'b0;
`ifdef BTP_OVF_DETECT_EN
      bus.ovf       <= 1'b0;
`endif
    end else if (!bus.stall) begin
      s1_valid      <= bus.in_valid;
      s1_pc         <= bus.pc_next;
      s1_off        <= bus.offset;
      s1_en         <= bus.branch_en;
      bus.out_valid <= s1_valid;
      bus.target    <= retire_taken ? sum : '0;
      bus.taken     <= retire_taken;
      if (retire_taken && !cnt_full) begin
        bus.taken_cnt <= bus.taken_cnt + 1'b1;
      end
`ifdef BTP_OVF_DETECT_EN
      bus.ovf       <= retire_taken & ovf_cond;
`endif
    end
  end

endmodule

// File: doc/branch_target_pipe.md
BRANCH_TARGET_PIPE -- requirements
Module: branch_target_pipe

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6: width of PC, offset and target.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the taken-branch counter.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1: the operands presented this cycle are valid.
REQ-006 The block SHALL have port pc_next, input, ADDR_W: incremented PC from the fetch buffer.
REQ-007 The block SHALL have port offset, input, ADDR_W: pre-shifted branch offset, two's complement.
REQ-008 The block SHALL have port branch_en, input, 1: branch condition (AND of branch opcode and zero flag).
REQ-009 The block SHALL have port stall, input, 1: hold the entire pipeline.
REQ-010 The block SHALL have port flush, input, 1: kill all in-flight entries.
REQ-011 The block SHALL have port out_valid, output, 1: target/taken are valid this cycle.
REQ-012 The block SHALL have port target, output, ADDR_W: branch target, or 0 when not taken.
REQ-013 The block SHALL have port taken, output, 1: registered branch_en of the retiring entry.
REQ-014 The block SHALL have port taken_cnt, output, CNT_W: saturating count of retired taken branches.
REQ-015 The block SHALL have port ovf, output, 1: signed overflow of the retiring sum; present only with the macro in REQ-031.

Function
REQ-016 The block SHALL be a 2-stage pipeline: S1 captures in_valid, pc_next, offset and branch_en; S2 computes the sum and registers the outputs.
REQ-017 Latency SHALL be exactly 2 cycles: operands accepted at edge N appear on the outputs after edge N+1.
REQ-018 The S2 sum SHALL be computed as (pc_next + offset) mod 2^ADDR_W; wrap-around is silent unless REQ-031 applies.
REQ-019 When the S1 branch_en is 0, S2 SHALL register target = 0 and taken = 0, irrespective of the operands.
REQ-020 When the S1 entry is invalid, S2 SHALL register out_valid = 0, target = 0 and taken = 0.
REQ-021 When stall = 1 and flush = 0, S1, S2, all outputs and taken_cnt SHALL hold their values; input operands are ignored that cycle.
REQ-022 When flush = 1, the S1 valid bit and the S2 valid bit SHALL clear at the next edge; outputs then read out_valid = 0, target = 0, taken = 0.
REQ-023 flush SHALL take priority over stall when both are asserted.
REQ-024 taken_cnt SHALL increment by 1 at each edge where S2 loads a valid entry with taken = 1 and no stall or flush is active.
REQ-025 taken_cnt SHALL saturate at 2^CNT_W - 1 and SHALL NOT wrap.
REQ-026 flush SHALL NOT clear taken_cnt.
REQ-027 Back-to-back valid inputs SHALL be accepted every unstalled cycle, giving a throughput of 1 per clock.

Reset
REQ-028 When rst = 1 at an edge, all valid bits, target, taken, taken_cnt and ovf SHALL clear to 0.
REQ-029 rst SHALL take priority over flush and stall.
REQ-030 Assertion of rst mid-operation SHALL discard in-flight entries; no output becomes valid until 2 cycles after the first accepted input following reset release.

Configuration
REQ-031 With macro BTP_OVF_DETECT_EN defined, the block SHALL drive ovf = 1 at S2 when the entry is valid, taken = 1, the signs of pc_next and offset are equal, and the sign of the sum differs from them; otherwise ovf = 0.
REQ-032 With macro BTP_OVF_DETECT_EN undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Basic taken (ADDR_W=6): pc_next=001100, offset=001100, branch_en=1 -> 2 cycles later out_valid=1, target=011000, taken=1.
REQ-034 Not-taken stream: {000000/000110/en0} then {001000/001010/en1} on consecutive cycles -> target=000000 then 010010 on consecutive cycles; taken_cnt advances by 1 only.
REQ-035 Wrap and overflow: 111000+001100, en=1 -> target=000100, ovf=0; then 011111+000001, en=1 -> target=100000, ovf=1 (macro defined).
REQ-036 Stall then flush: an entry sitting in S1 with stall held 3 cycles -> outputs frozen for those cycles; then flush together with stall -> out_valid=0 next cycle, with taken_cnt unchanged.
REQ-037 Saturation and reset: CNT_W=4 with 20 taken branches -> taken_cnt=1111; rst pulsed mid-stream -> all outputs 0 at the next edge.
